// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory controller and its storage array.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        RD_WORD  = 2'd0,
        WR_WORD  = 2'd1,
        RD_BLOCK = 2'd2,
        WR_BLOCK = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    function automatic logic op_is_write(input mem_op_e op);
        return (op == WR_WORD) || (op == WR_BLOCK);
    endfunction

    function automatic logic op_is_block(input mem_op_e op);
        return (op == RD_BLOCK) || (op == WR_BLOCK);
    endfunction

endpackage

// File: rtl/main_memory_array.sv
// Block-organised storage with a registered block/word read port and a byte-masked write port.
module main_memory_array
    import mem_pkg::*;
#(
    parameter  int BLOCK_BYTES = 32,
    parameter  int NUM_BLOCKS  = 2048,
    parameter  int PRELOAD     = 1,
    localparam int BLOCK_W     = 8 * BLOCK_BYTES,
    localparam int WPB         = BLOCK_BYTES / 4,
    localparam int OFF_W       = $clog2(BLOCK_BYTES),
    localparam int BLK_W       = $clog2(NUM_BLOCKS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               acc_en,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic               block_op,
    input  logic [BLK_W-1:0]   blk,
    input  logic [OFF_W-1:0]   offset,
    input  logic [BLOCK_W-1:0] wdata,
    input  logic [STRB_W-1:0]  wstrb,
    output logic [BLOCK_W-1:0] rdata
);

    typedef logic [BLOCK_W-1:0] image_t [NUM_BLOCKS];

    function automatic image_t build_image();
        image_t img;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            img[b] = '0;
            for (int w = 0; w < WPB; w++) begin
                if (PRELOAD != 0 && b == 0)
                    img[b][w*WORD_W +: WORD_W] = 32'h1000_0000 + WORD_W'(w);
                else if (PRELOAD != 0 && b == NUM_BLOCKS / 2)
                    img[b][w*WORD_W +: WORD_W] = 32'h2000_0000 + WORD_W'(w);
            end
        end
        return img;
    endfunction

    // Contents come up with the preload image and are deliberately never reset.
    logic [BLOCK_W-1:0] mem [NUM_BLOCKS] = build_image();

    logic [BLOCK_W-1:0] byte_mask;
    logic [BLOCK_W-1:0] wr_value;
    int                 word_idx;

    always_comb begin
        byte_mask = '0;
        wr_value  = '0;
        word_idx  = int'(offset >> 2);
        if (block_op) begin
            byte_mask = '1;
            wr_value  = wdata;
        end else begin
            for (int i = 0; i < STRB_W; i++)
                byte_mask[word_idx*WORD_W + i*8 +: 8] = {8{wstrb[i]}};
            wr_value = {WPB{wdata[WORD_W-1:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (acc_en && wr_en)
            mem[blk] <= (mem[blk] & ~byte_mask) | (wr_value & byte_mask);
    end

    // Writes and rejected requests answer with zero data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (acc_en) begin
            if (rd_en)
                rdata <= block_op ? mem[blk] : BLOCK_W'(mem[blk][word_idx*WORD_W +: WORD_W]);
            else
                rdata <= '0;
        end
    end

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory front end: request/response handshakes, programmable access latency and error checks.
module main_memory_ctrl
    import mem_pkg::*;
#(
    parameter  int BLOCK_BYTES = 32,
    parameter  int NUM_BLOCKS  = 2048,
    parameter  int LATENCY     = 4,
    parameter  int PRELOAD     = 1,
    parameter  int ADDR_W      = $clog2(NUM_BLOCKS * BLOCK_BYTES),
    localparam int BLOCK_W     = 8 * BLOCK_BYTES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [BLOCK_W-1:0] req_wdata,
    input  logic [STRB_W-1:0]  req_wstrb,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [BLOCK_W-1:0] resp_rdata,
    output logic               resp_err,
    output logic               busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // sender keeps its payload stable while valid is high and ready is low.

    localparam int OFF_W  = $clog2(BLOCK_BYTES);
    localparam int ARR_AW = $clog2(NUM_BLOCKS * BLOCK_BYTES);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam longint unsigned MEM_BYTES = longint'(NUM_BLOCKS) * longint'(BLOCK_BYTES);

    mem_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    mem_op_e             op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BLOCK_W-1:0]  wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                resp_valid_q, resp_err_q;
    logic                accept, access, resp_done;
    logic                req_err;

    always_comb begin
        req_err = (!op_is_block(op_q) && addr_q[1:0] != 2'b00)
                || (64'(addr_q) >= MEM_BYTES);
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        access    = 1'b0;
        resp_done = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Loading LATENCY-1 puts the array access on the LATENCY-th edge after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= CNT_W'(LATENCY - 1);
        else if (state_q == WAIT && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= RD_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            op_q    <= mem_op_e'(req_op);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else if (access) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= req_err;
        end else if (resp_done) begin
            resp_valid_q <= 1'b0;
        end
    end

    main_memory_array #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .NUM_BLOCKS  (NUM_BLOCKS),
        .PRELOAD     (PRELOAD)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .acc_en   (access),
        .wr_en    (op_is_write(op_q) && !req_err),
        .rd_en    (!op_is_write(op_q) && !req_err),
        .block_op (op_is_block(op_q)),
        .blk      (addr_q[ARR_AW-1:OFF_W]),
        .offset   (addr_q[OFF_W-1:0]),
        .wdata    (wdata_q),
        .wstrb    (wstrb_q),
        .rdata    (resp_rdata)
    );

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl with default parameters (32-byte blocks, 2048 blocks, latency 4).
module tb_main_memory_ctrl;

    localparam logic [1:0] OP_RD_WORD  = 2'd0;
    localparam logic [1:0] OP_WR_WORD  = 2'd1;
    localparam logic [1:0] OP_RD_BLOCK = 2'd2;
    localparam logic [1:0] OP_WR_BLOCK = 2'd3;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [15:0]  req_addr;
    logic [255:0] req_wdata;
    logic [3:0]   req_wstrb;
    logic         resp_valid;
    logic         resp_ready;
    logic [255:0] resp_rdata;
    logic         resp_err;
    logic         busy;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [255:0] exp_blk0;
    logic [255:0] pat_a5;
    int           n;

    main_memory_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for req_ready, then presents one request for a single accept edge.
    task automatic send(input logic [1:0] op, input logic [15:0] addr,
                        input logic [255:0] wd, input logic [3:0] st);
        int k;
        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("req_ready_before_send", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = st;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Counts edges from the accept edge to resp_valid, checks payload, then consumes it.
    task automatic get_resp(input string tag, input logic [255:0] exp_data, input logic exp_err);
        int k;
        k = 0;
        while (!resp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, k, 4);
        check({tag, "_rdata"}, resp_rdata, exp_data);
        check({tag, "_err"}, resp_err, exp_err);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int w = 0; w < 8; w++) exp_blk0[w*32 +: 32] = 32'h1000_0000 + 32'(w);
        pat_a5 = {32{8'hA5}};

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_op     = OP_RD_WORD;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b1;

        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_busy", busy, 0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // Preloaded block 0 read
        send(OP_RD_BLOCK, 16'h0000, '0, 4'h0);
        check("wait_busy", busy, 1);
        check("wait_req_ready", req_ready, 0);
        get_resp("rd_blk0", exp_blk0, 1'b0);

        // Byte-strobed word write into preloaded block 1024
        send(OP_WR_WORD, 16'h8004, 256'hDEAD_BEEF, 4'b0101);
        get_resp("wr_word_8004", 256'h0, 1'b0);
        send(OP_RD_WORD, 16'h8004, '0, 4'h0);
        get_resp("rd_word_8004", 256'h20AD_00EF, 1'b0);

        // Block write then read with low address bits set
        send(OP_WR_BLOCK, 16'h0020, pat_a5, 4'h0);
        get_resp("wr_blk_0020", 256'h0, 1'b0);
        send(OP_RD_BLOCK, 16'h003F, '0, 4'h0);
        get_resp("rd_blk_003f", pat_a5, 1'b0);
        send(OP_RD_WORD, 16'h0024, '0, 4'h0);
        get_resp("rd_word_0024", 256'hA5A5_A5A5, 1'b0);

        // Misaligned word ops are rejected and do not write
        send(OP_RD_WORD, 16'h0002, '0, 4'h0);
        get_resp("rd_misaligned", 256'h0, 1'b1);
        send(OP_WR_WORD, 16'h0001, 256'hFFFF_FFFF, 4'hF);
        get_resp("wr_misaligned", 256'h0, 1'b1);
        send(OP_RD_WORD, 16'h0000, '0, 4'h0);
        get_resp("rd_after_err", 256'h1000_0000, 1'b0);

        // Empty strobe is a no-op that still answers
        send(OP_WR_WORD, 16'h8008, 256'hFFFF_FFFF, 4'h0);
        get_resp("wr_strb0", 256'h0, 1'b0);
        send(OP_RD_WORD, 16'h8008, '0, 4'h0);
        get_resp("rd_after_strb0", 256'h2000_0002, 1'b0);

        // Response back-pressure: output held, next request stalled
        resp_ready = 1'b0;
        send(OP_RD_WORD, 16'h8000, '0, 4'h0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_latency", n, 4);
        req_valid = 1'b1;
        req_op    = OP_RD_WORD;
        req_addr  = 16'h0004;
        for (int i = 0; i < 10; i++) begin
            check("bp_resp_valid", resp_valid, 1);
            check("bp_resp_rdata", resp_rdata, 256'h2000_0000);
            check("bp_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_after_hs_valid", resp_valid, 0);
        check("bp_after_hs_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_second_busy", busy, 1);
        get_resp("bp_second", 256'h1000_0001, 1'b0);

        // Asynchronous reset while a word write waits: write must be dropped
        send(OP_WR_WORD, 16'h0000, 256'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        check("pre_reset_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_req_ready", req_ready, 1);
        check("async_rst_resp_valid", resp_valid, 0);
        check("async_rst_rdata", resp_rdata, 0);
        check("async_rst_err", resp_err, 0);
        check("async_rst_busy", busy, 0);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        send(OP_RD_WORD, 16'h0000, '0, 4'h0);
        get_resp("rd_after_reset", 256'h1000_0000, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
Parametrised main-memory model behind the cache: a block-organised array (BLOCK_BYTES per block, NUM_BLOCKS blocks) fronted by a single valid/ready request channel and a valid/ready response channel. It supports block read/write (fill/writeback) and word read/write with byte strobes, adds a programmable access latency to model slow memory, and flags out-of-range or misaligned requests. It replaces the fixed 256-bit/2048-block memory, whose ports had no handshake.

Parameters:
BLOCK_BYTES, 32, bytes per block; power of two, >=4
NUM_BLOCKS, 2048, blocks in the array; power of two
LATENCY, 4, cycles from request accept to response valid; >=1
PRELOAD, 1, 1: block 0 word w = 0x1000_0000+w and block NUM_BLOCKS/2 word w = 0x2000_0000+w; all other words 0. 0: all words 0
Derived: BLOCK_W = 8*BLOCK_BYTES. WPB = BLOCK_BYTES/4. ADDR_W = clog2(NUM_BLOCKS*BLOCK_BYTES).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_op  in  2  0 RD_WORD, 1 WR_WORD, 2 RD_BLOCK, 3 WR_BLOCK
req_addr  in  ADDR_W  byte address
req_wdata  in  BLOCK_W  block write data; a word write uses bits [31:0]
req_wstrb  in  4  byte enables for WR_WORD; ignored otherwise
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_rdata  out  BLOCK_W  read data; a word read is zero-extended in [31:0]; 0 for writes
resp_err  out  1  request rejected (range or alignment)
busy  out  1  state != IDLE

Behaviour:
- Reset assertion (reset=0), at any time: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Array contents are not touched by reset. An in-flight request is dropped; its write is not performed if the array access has not yet occurred.
- FSM states are IDLE, WAIT, RESP.
- IDLE: req_ready=1. On accept, capture op/addr/wdata/wstrb, load cnt=LATENCY-1, go to WAIT. Requests arriving in any other state stall, because req_ready=0.
- WAIT: if cnt!=0, decrement cnt. If cnt==0, perform the array access on this edge, register resp_rdata/resp_err, set resp_valid=1, go to RESP.
- Resulting timing: for an accept at edge T, resp_valid=1 after edge T+LATENCY.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_ready. On the handshake, resp_valid=0 and the state returns to IDLE. The next accept is possible no earlier than the edge after that, so throughput is one request per LATENCY+2 cycles with resp_ready tied high.
- Indexing: block = addr[ADDR_W-1:clog2(BLOCK_BYTES)]; word = addr[clog2(BLOCK_BYTES)-1:2]. Block ops ignore the low clog2(BLOCK_BYTES) bits.
- WR_WORD: only the bytes enabled in wstrb are written. wstrb=0 is a legal no-op and still produces a response.
- Error cases: word op with addr[1:0]!=0, or any address >= NUM_BLOCKS*BLOCK_BYTES (only reachable when ADDR_W is wider than the array). Response: resp_err=1, no array write, resp_rdata=0, same timing as a normal request.
- A read returns data as of the access edge. There is no concurrency inside the block, so there is no read/write collision.

Decomposition:
- Package mem_pkg holds mem_op_e (RD_WORD, WR_WORD, RD_BLOCK, WR_BLOCK), the state enum mem_state_e, and the WORD_W=32 / STRB_W=4 constants.
- Sub-module main_memory_array holds the storage, the PRELOAD initial block, a synchronous block/word read port, and a write port with per-byte enables (BLOCK_W-wide byte mask built from wstrb and word index). main_memory_ctrl contains the FSM, latency counter, error check and response registers.

Test Plan:
- Defaults, RD_BLOCK addr 0x0000 accepted at edge T -> resp_valid after edge T+4; resp_rdata word w = 0x1000_0000+w; resp_err=0.
- WR_WORD addr 0x8004, wdata 0xDEADBEEF, wstrb 0b0101 -> ack; then RD_WORD 0x8004 returns 0x20AD00EF (block 1024 word 1 originally 0x2000_0001).
- WR_BLOCK addr 0x0020 with pattern 0xA5.. -> ack; RD_BLOCK 0x003F returns the same 256 bits, since low bits are ignored.
- RD_WORD addr 0x0002 -> resp_err=1, resp_rdata=0; memory unchanged.
- Hold resp_ready=0 for 10 cycles -> resp_valid/resp_rdata stable, req_ready=0 throughout; second request is accepted only after the response handshake.
- Assert reset in WAIT of a WR_WORD to 0x0000 -> outputs reach reset values immediately (asynchronously); a subsequent RD_WORD 0x0000 returns 0x1000_0000.
